// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry, fill FSM states and the byte-lane mask helper.
package fb_pkg;

    localparam int unsigned FB_WIDTH   = 400;
    localparam int unsigned FB_HEIGHT  = 300;
    localparam int unsigned X_BITS     = 9;
    localparam int unsigned Y_BITS     = 9;
    localparam int unsigned ADDR_BITS  = 17;
    localparam int unsigned COLOR_BITS = 6;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        FILL,
        DONE
    } fill_state_t;

    // Enable lanes first_lane..last_lane inclusive within one 32-bit word.
    function automatic logic [3:0] lane_mask(input logic [1:0] first_lane,
                                             input logic [1:0] last_lane);
        logic [3:0] m;
        m = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (2'(i) >= first_lane && 2'(i) <= last_lane) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/rect_fill_engine_if.sv
// Command handshake plus frame-buffer write port of the rectangle fill engine.
interface rect_fill_engine_if;
    import fb_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [X_BITS-1:0]     cmd_x;
    logic [Y_BITS-1:0]     cmd_y;
    logic [X_BITS-1:0]     cmd_w;
    logic [Y_BITS-1:0]     cmd_h;
    logic [COLOR_BITS-1:0] cmd_color;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [31:0]           buffer_addr;
    logic [31:0]           buffer_din;
    logic                  buffer_en;
    logic                  buffer_rst;
    logic [3:0]            buffer_we;

    // Command issuer / frame-buffer side.
    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        input  cmd_ready, busy, done, err,
        input  buffer_addr, buffer_din, buffer_en, buffer_rst, buffer_we
    );

    // Engine side.
    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        output cmd_ready, busy, done, err,
        output buffer_addr, buffer_din, buffer_en, buffer_rst, buffer_we
    );

endinterface

// File: rtl/fb_row_walker.sv
// Column cursor for one rectangle row: current word span, lane mask, end-of-row flag.
module fb_row_walker
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [X_BITS-1:0] load_x,
    input  logic [X_BITS-1:0] x_start,
    input  logic [X_BITS:0]   x_end,
    input  logic              advance,
    output logic [X_BITS:0]   cx,
    output logic [3:0]        lanes,
    output logic              row_end
);

    localparam logic [X_BITS:0] ONE  = 1;
    localparam logic [X_BITS:0] STEP = 4;

    logic [X_BITS:0] cx_q, cx_d;
    logic [X_BITS:0] x_last;
    logic [X_BITS:0] word_base;

    // Lane span of the word under the cursor and the cursor's next position.
    always_comb begin
        x_last    = x_end - ONE;
        word_base = {cx_q[X_BITS:2], 2'b00};
        row_end   = (x_last[X_BITS:2] == cx_q[X_BITS:2]);
        lanes     = lane_mask(cx_q[1:0], row_end ? x_last[1:0] : 2'd3);
        cx_d      = cx_q;
        if (load) begin
            cx_d = {1'b0, load_x};
        end else if (advance) begin
            cx_d = row_end ? {1'b0, x_start} : word_base + STEP;
        end
    end

    // Cursor register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cx_q <= '0;
        else     cx_q <= cx_d;
    end

    assign cx = cx_q;

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: accepts fill commands and writes up to 4 pixels per cycle
// into the byte-addressed frame buffer. Define RECT_CLIP_EN to clip rectangles to the
// frame instead of rejecting out-of-bounds commands with err.
module rect_fill_engine
    import fb_pkg::*;
(
    input logic               clk,
    input logic               rst,
    rect_fill_engine_if.slave bus
);

    localparam logic [X_BITS:0]    X_LIMIT = (X_BITS + 1)'(FB_WIDTH);
    localparam logic [Y_BITS:0]    Y_LIMIT = (Y_BITS + 1)'(FB_HEIGHT);
    localparam logic [Y_BITS:0]    Y_ONE   = 1;
    localparam logic [ADDR_BITS-1:0] ROW_STEP = ADDR_BITS'(FB_WIDTH);

    fill_state_t state_q, state_d;

    logic [X_BITS-1:0]     x_q, x_d, w_q, w_d;
    logic [Y_BITS-1:0]     y_q, y_d, h_q, h_d;
    logic [COLOR_BITS-1:0] color_q, color_d;
    logic [Y_BITS:0]       ry_q, ry_d;
    logic [ADDR_BITS-1:0]  row_base_q, row_base_d;
    logic                  last_q, last_d;

    logic        ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic        en_q, en_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] addr_q, addr_d, din_q, din_d;

    logic [X_BITS:0]      x_end_raw, x_end, cx;
    logic [Y_BITS:0]      y_end_raw, y_end;
    logic                 reject, empty, accept, issue, row_end;
    logic [3:0]           lanes;
    logic [ADDR_BITS-1:0] rb_cur, pix_index;

    assign accept = ready_q && bus.cmd_valid;

    fb_row_walker u_walker (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .load_x  (bus.cmd_x),
        .x_start (x_q),
        .x_end   (x_end),
        .advance (issue),
        .cx      (cx),
        .lanes   (lanes),
        .row_end (row_end)
    );

    // Rectangle extents from the latched command and the bounds rule.
    always_comb begin
        x_end_raw = {1'b0, x_q} + {1'b0, w_q};
        y_end_raw = {1'b0, y_q} + {1'b0, h_q};
`ifdef RECT_CLIP_EN
        x_end  = (x_end_raw > X_LIMIT) ? X_LIMIT : x_end_raw;
        y_end  = (y_end_raw > Y_LIMIT) ? Y_LIMIT : y_end_raw;
        reject = 1'b0;
`else
        x_end  = x_end_raw;
        y_end  = y_end_raw;
        reject = (x_end_raw > X_LIMIT) || (y_end_raw > Y_LIMIT);
`endif
        empty = (x_end <= {1'b0, x_q}) || (y_end <= {1'b0, y_q});
    end

    // Next state, command latch, row stepping and registered port values.
    // The first word is issued from SETUP so registered writes land in the FILL cycles;
    // FILL then runs one cycle past the last issue to present it.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        w_d        = w_q;
        h_d        = h_q;
        color_d    = color_q;
        ry_d       = ry_q;
        row_base_d = row_base_q;
        last_d     = last_q;
        issue      = 1'b0;
        rb_cur     = (state_q == SETUP) ? ADDR_BITS'(y_q) * ROW_STEP : row_base_q;
        pix_index  = rb_cur + ADDR_BITS'(cx);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                    x_d     = bus.cmd_x;
                    y_d     = bus.cmd_y;
                    w_d     = bus.cmd_w;
                    h_d     = bus.cmd_h;
                    color_d = bus.cmd_color;
                    ry_d    = {1'b0, bus.cmd_y};
                    last_d  = 1'b0;
                end
            end
            SETUP: begin
                if (reject || empty) begin
                    state_d = DONE;
                end else begin
                    state_d = FILL;
                    issue   = 1'b1;
                end
            end
            FILL: begin
                if (last_q) state_d = DONE;
                else        issue   = 1'b1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (issue) begin
            row_base_d = rb_cur;
            if (row_end) begin
                if (ry_q + Y_ONE == y_end) begin
                    last_d = 1'b1;
                end else begin
                    row_base_d = rb_cur + ROW_STEP;
                    ry_d       = ry_q + Y_ONE;
                end
            end
        end

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        err_d   = (state_q == SETUP) && reject;
        en_d    = issue;
        we_d    = issue ? lanes : '0;
        addr_d  = issue ? (32'(pix_index) & 32'hFFFF_FFFC) : addr_q;
        din_d   = issue ? {4{8'(color_q)}} : din_q;
    end

    // State, command and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            color_q    <= '0;
            ry_q       <= '0;
            row_base_q <= '0;
            last_q     <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            en_q       <= 1'b0;
            we_q       <= '0;
            addr_q     <= '0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            w_q        <= w_d;
            h_q        <= h_d;
            color_q    <= color_d;
            ry_q       <= ry_d;
            row_base_q <= row_base_d;
            last_q     <= last_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            en_q       <= en_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
        end
    end

    assign bus.cmd_ready   = ready_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.buffer_en   = en_q;
    assign bus.buffer_we   = we_q;
    assign bus.buffer_addr = addr_q;
    assign bus.buffer_din  = din_q;
    assign bus.buffer_rst  = 1'b0;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: directed and random fill commands checked
// against a per-pixel reference model of the frame-buffer writes.
module tb_rect_fill_engine;
    import fb_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
    } wr_t;

    logic clk = 1'b0;
    logic rst;

    rect_fill_engine_if bus();

    rect_fill_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    wr_t  exp_q[$];
    logic exp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected word writes: walk every covered pixel in raster order, merging pixels
    // that share a 32-bit word.
    task automatic build_model(input int x, input int y, input int w, input int h);
        int xe, ye, idx;
        logic [31:0] a, cur_a;
        logic [3:0]  cur_we;
        logic        have;
        exp_q.delete();
        exp_err = 1'b0;
        xe = x + w;
        ye = y + h;
`ifdef RECT_CLIP_EN
        if (xe > int'(FB_WIDTH))  xe = FB_WIDTH;
        if (ye > int'(FB_HEIGHT)) ye = FB_HEIGHT;
`else
        if (xe > int'(FB_WIDTH) || ye > int'(FB_HEIGHT)) begin
            exp_err = 1'b1;
            return;
        end
`endif
        have   = 1'b0;
        cur_a  = '0;
        cur_we = '0;
        for (int r = y; r < ye; r++) begin
            for (int p = x; p < xe; p++) begin
                idx = r * int'(FB_WIDTH) + p;
                a   = 32'(idx - (idx % 4));
                if (have && a == cur_a) begin
                    cur_we[idx % 4] = 1'b1;
                end else begin
                    if (have) exp_q.push_back('{cur_a, cur_we});
                    cur_a  = a;
                    cur_we = 4'b0001 << (idx % 4);
                    have   = 1'b1;
                end
            end
        end
        if (have) exp_q.push_back('{cur_a, cur_we});
    endtask

    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input logic [5:0] col);
        int          k, wi, n;
        logic        seen_done;
        logic [31:0] exp_din;
        build_model(x, y, w, h);
        n       = exp_q.size();
        exp_din = {4{2'b00, col}};
        @(negedge clk);
        bus.cmd_x     = X_BITS'(x);
        bus.cmd_y     = Y_BITS'(y);
        bus.cmd_w     = X_BITS'(w);
        bus.cmd_h     = Y_BITS'(h);
        bus.cmd_color = col;
        bus.cmd_valid = 1'b1;
        chk("ready_before", 32'(bus.cmd_ready), 1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_x     = X_BITS'($urandom);
        bus.cmd_w     = X_BITS'($urandom);
        bus.cmd_color = COLOR_BITS'($urandom);
        chk("setup_busy", 32'(bus.busy), 1);
        chk("setup_ready", 32'(bus.cmd_ready), 0);
        chk("setup_en", 32'(bus.buffer_en), 0);
        wi        = 0;
        seen_done = 1'b0;
        for (k = 2; k < n + 8; k++) begin
            @(negedge clk);
            chk("busy", 32'(bus.busy), 1);
            if (bus.buffer_en) begin
                if (wi < n) begin
                    chk("write_cycle", 32'(k), 32'(wi + 2));
                    chk("addr", bus.buffer_addr, exp_q[wi].addr);
                    chk("we", 32'(bus.buffer_we), 32'(exp_q[wi].we));
                    chk("din", bus.buffer_din, exp_din);
                end else begin
                    chk("write_count", 32'(wi + 1), 32'(n));
                end
                wi++;
            end
            if (bus.done) begin
                seen_done = 1'b1;
                chk("done_cycle", 32'(k), 32'(n + 2));
                chk("err", 32'(bus.err), 32'(exp_err));
                chk("done_en", 32'(bus.buffer_en), 0);
                chk("write_total", 32'(wi), 32'(n));
                break;
            end
        end
        if (!seen_done) chk("done_timeout", 32'(seen_done), 1);
        @(negedge clk);
        chk("ready_after", 32'(bus.cmd_ready), 1);
        chk("busy_after", 32'(bus.busy), 0);
        chk("done_pulse", 32'(bus.done), 0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_w     = '0;
        bus.cmd_h     = '0;
        bus.cmd_color = '0;
        #1;
        chk("rst_ready", 32'(bus.cmd_ready), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_en", 32'(bus.buffer_en), 0);
        chk("rst_we", 32'(bus.buffer_we), 0);
        chk("rst_addr", bus.buffer_addr, 0);
        chk("rst_din", bus.buffer_din, 0);
        chk("rst_brst", 32'(bus.buffer_rst), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_ready", 32'(bus.cmd_ready), 1);
            chk("idle_en", 32'(bus.buffer_en), 0);
            chk("idle_done", 32'(bus.done), 0);
        end

        // Directed commands.
        run_cmd(2, 1, 7, 1, 6'h2A);
        run_cmd(0, 0, 4, 3, 6'h15);
        run_cmd(10, 20, 0, 5, 6'h3F);
        run_cmd(398, 299, 4, 2, 6'h01);
        run_cmd(396, 0, 4, 1, 6'h07);
        run_cmd(1, 299, 2, 1, 6'h10);

        // Random commands, biased to straddle the right and bottom edges.
        for (int i = 0; i < 40; i++) begin
            run_cmd($urandom_range(0, 410), $urandom_range(0, 305),
                    $urandom_range(0, 24), $urandom_range(0, 4),
                    6'($urandom));
        end

        // Reset during a full-frame fill.
        @(negedge clk);
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_w     = X_BITS'(400);
        bus.cmd_h     = Y_BITS'(300);
        bus.cmd_color = 6'h33;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("fill_active", 32'(bus.buffer_en), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_en", 32'(bus.buffer_en), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_done", 32'(bus.done), 0);
        chk("abort_ready", 32'(bus.cmd_ready), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(bus.done), 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_abort_idle_done", 32'(bus.done), 0);
            chk("post_abort_idle_en", 32'(bus.buffer_en), 0);
        end
        run_cmd(5, 7, 9, 2, 6'h2C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
